// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide unit for the E stage. It owns HI/LO, holds busy for a
// fixed latency, and requests a D/E stall while an MD instruction would see stale HI/LO.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_hi_lo_E
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          sgn_q, busy_q;

  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_b, quo_mag, rem_mag, quo_d, rem_d;
  logic [31:0] hi_d, lo_d;

  // Division works on magnitudes so the INT_MIN / -1 case falls out without overflow.
  always_comb begin
    a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
    b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
    prod    = a_ext * b_ext;
    a_neg   = sgn_q & a_q[31];
    b_neg   = sgn_q & b_q[31];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    div_b   = (b_mag == 32'h0) ? 32'h1 : b_mag;
    quo_mag = a_mag / div_b;
    rem_mag = a_mag % div_b;
    quo_d   = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem_d   = a_neg ? -rem_mag : rem_mag;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MUL: begin
        hi_d = prod[63:32];
        lo_d = prod[31:0];
      end
      DIV: if (b_q != 32'h0) begin
        hi_d = rem_d;
        lo_d = quo_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          case (md_op)
            3'b000, 3'b001: begin
              a_q     <= A;
              b_q     <= B;
              sgn_q   <= ~md_op[0];
              cnt_q   <= CW'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= MUL;
            end
            3'b010, 3'b011: begin
              a_q     <= A;
              b_q     <= B;
              sgn_q   <= ~md_op[0];
              cnt_q   <= CW'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= DIV;
            end
            3'b100:  hi_q <= A;
            3'b101:  lo_q <= A;
            default: ;
          endcase
        end
        default: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign stall_req  = md_use_D & (busy_q | (start & ~md_op[2]));
  assign HI         = hi_q;
  assign LO         = lo_q;
  assign MD_hi_lo_E = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: vector table through a result scoreboard, plus hand
// sequences for start-while-busy, stall coverage and mid-operation reset.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, rd_sel, md_use_D;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy, stall_req;
  logic [31:0] HI, LO, MD_hi_lo_E;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .rd_sel(rd_sel), .md_use_D(md_use_D), .busy(busy), .stall_req(stall_req),
    .HI(HI), .LO(LO), .MD_hi_lo_E(MD_hi_lo_E)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
  } exp_t;

  vec_t vt[13];
  exp_t sbq[$];
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else npass++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    exp_t e;
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    #1;
    chk("stall_issue", {31'b0, stall_req}, {31'b0, md_use_D & ~op[2]});
    e.hi = ehi; e.lo = elo; e.cyc = cyc;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    exp_t e;
    int   n;
    e = sbq.pop_front();
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      chk({nm, "_stall_busy"}, {31'b0, stall_req}, {31'b0, md_use_D});
      n++;
      @(negedge clk);
    end
    chk({nm, "_cycles"}, n, e.cyc);
    chk({nm, "_HI"}, HI, e.hi);
    chk({nm, "_LO"}, LO, e.lo);
    chk({nm, "_stall_done"}, {31'b0, stall_req}, 32'h0);
    rd_sel = 1'b0; #1;
    chk({nm, "_rd_hi"}, MD_hi_lo_E, e.hi);
    rd_sel = 1'b1; #1;
    chk({nm, "_rd_lo"}, MD_hi_lo_E, e.lo);
  endtask

  initial begin
    vt[0]  = '{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vt[1]  = '{3'b001, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 5};
    vt[2]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    vt[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    vt[5]  = '{3'b100, 32'h11,       32'h0,        32'h11,       32'h80000000, 0};
    vt[6]  = '{3'b101, 32'h22,       32'h0,        32'h11,       32'h22,       0};
    vt[7]  = '{3'b010, 32'd5,        32'h0,        32'h11,       32'h22,       10};
    vt[8]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vt[9]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5};
    vt[10] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};
    vt[11] = '{3'b011, 32'hFFFFFFFF, 32'd2,        32'h1,        32'h7FFFFFFF, 10};
    vt[12] = '{3'b110, 32'h99,       32'h99,       32'h1,        32'h7FFFFFFF, 0};

    reset = 1'b0; start = 1'b0; md_op = 3'b0; A = '0; B = '0;
    rd_sel = 1'b0; md_use_D = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_HI", HI, 32'h0);
    chk("rst_LO", LO, 32'h0);
    chk("rst_stall", {31'b0, stall_req}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      md_use_D = i[0];
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].cyc);
      wait_done($sformatf("vec%0d", i));
    end

    // start during busy, including mtlo, must not disturb the latched operation
    md_use_D = 1'b0;
    issue(3'b000, 32'd3, 32'd4, 32'h0, 32'd12, 5);
    @(negedge clk);
    chk("ovl_busy", {31'b0, busy}, 32'h1);
    start = 1'b1; md_op = 3'b101; A = 32'h55; B = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    sbq[0].cyc = 4;
    wait_done("ovl");

    md_use_D = 1'b1;
    issue(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_done("stall_on");
    md_use_D = 1'b0;
    issue(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_done("stall_off");

    // reset in the third busy cycle of a div
    issue(3'b010, 32'd50, 32'd3, 32'h0, 32'h0, 10);
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0; #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_HI", HI, 32'h0);
    chk("mid_rst_LO", LO, 32'h0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    issue(3'b000, 32'd6, 32'd7, 32'h0, 32'd42, 5);
    wait_done("post_rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
